nonce_collector: RTL

Parametrised golden-nonce collector between the hashcore array and the host-facing reporting logic. Captures match pulses from `LOCAL_MINERS` cores into per-core holding registers, drains them into a shared FIFO under round-robin arbitration, and presents queued nonces with their core index on a valid/ready port. This replaces the single-register probe scheme, which could report only one nonce at a time and lost nonces when cores matched close together.

---
 rtl/nonce_collector.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/nonce_collector.sv
// Golden-nonce collector: per-core holding registers, round-robin drain into a FWFT FIFO.
// Optional drop counter built only when NONCE_DROP_COUNT_EN is defined.
module nonce_collector #(
    parameter int LOCAL_MINERS = 4,
    parameter int FIFO_DEPTH   = 8,
    parameter int CW           = 4
) (
    input  logic                          hash_clk,
    input  logic                          rst_n,
    input  logic [LOCAL_MINERS*32-1:0]    golden_nonce_i,
    input  logic [LOCAL_MINERS-1:0]       golden_nonce_match,
    output logic                          out_valid,
    output logic [31:0]                   out_nonce,
    output logic [CW-1:0]                 out_core,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [15:0]                   drop_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW:0] LM_C    = (CW+1)'(LOCAL_MINERS);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    logic [LOCAL_MINERS-1:0] pend_vec;
    logic [31:0]             hold_arr [LOCAL_MINERS];
    logic [LOCAL_MINERS-1:0] grant_oh;
    logic [LOCAL_MINERS-1:0] pend_rot;
    logic                    found;
    logic                    grant_vld;
    logic [CW-1:0]           grant_off;
    logic [CW-1:0]           grant_idx;
    logic [CW:0]             grant_sum;
    logic [CW:0]             rr_inc;
    logic [CW-1:0]           rr_ptr_q, rr_ptr_d;
    logic [31:0]             hold_sel;

    logic [31:0]             mem_nonce [FIFO_DEPTH];
    logic [CW-1:0]           mem_core  [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [AW:0]             count_q, count_d;
    logic                    fifo_full;
    logic                    push;
    logic                    pop;

    assign fifo_full = (count_q == DEPTH_C);
    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;
    assign push      = grant_vld;

    // Rotate pending bits so bit 0 is the current highest-priority core.
    assign pend_rot = LOCAL_MINERS'({pend_vec, pend_vec} >> rr_ptr_q);

    always_comb begin
        found     = 1'b0;
        grant_off = '0;
        for (int i = 0; i < LOCAL_MINERS; i++) begin
            if (!found && pend_rot[i]) begin
                found     = 1'b1;
                grant_off = CW'(i);
            end
        end
        grant_vld = found && !fifo_full;
        grant_sum = {1'b0, rr_ptr_q} + {1'b0, grant_off};
        grant_idx = (grant_sum >= LM_C) ? CW'(grant_sum - LM_C) : grant_sum[CW-1:0];
        rr_inc    = {1'b0, grant_idx} + (CW+1)'(1);
        rr_ptr_d  = rr_ptr_q;
        if (grant_vld) begin
            rr_ptr_d = (rr_inc >= LM_C) ? '0 : rr_inc[CW-1:0];
        end
    end

    for (genvar gi = 0; gi < LOCAL_MINERS; gi++) begin : g_core
        logic        pend_q;
        logic [31:0] hold_q;
        logic        capture;

        assign grant_oh[gi] = grant_vld && (grant_idx == CW'(gi));
        // A core granted this cycle frees its slot, so a coincident match is captured, not dropped.
        assign capture      = golden_nonce_match[gi] && (!pend_q || grant_oh[gi]);
        assign pend_vec[gi] = pend_q;
        assign hold_arr[gi] = hold_q;

        always_ff @(posedge hash_clk or negedge rst_n) begin
            if (!rst_n) begin
                pend_q <= 1'b0;
            end else if (capture) begin
                pend_q <= 1'b1;
            end else if (grant_oh[gi]) begin
                pend_q <= 1'b0;
            end
        end

        always_ff @(posedge hash_clk) begin
            if (capture) begin
                hold_q <= golden_nonce_i[gi*32 +: 32];
            end
        end
    end

    always_comb begin
        hold_sel = '0;
        for (int i = 0; i < LOCAL_MINERS; i++) begin
            if (grant_oh[i]) begin
                hold_sel = hold_sel | hold_arr[i];
            end
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!push && pop) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge hash_clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge hash_clk) begin
        if (push) begin
            mem_nonce[wr_ptr_q] <= hold_sel;
            mem_core[wr_ptr_q]  <= grant_idx;
        end
    end

    // Gate the head with valid so outputs read zero after reset regardless of RAM contents.
    assign out_nonce  = out_valid ? mem_nonce[rd_ptr_q] : '0;
    assign out_core   = out_valid ? mem_core[rd_ptr_q]  : '0;
    assign fifo_count = count_q;

`ifdef NONCE_DROP_COUNT_EN
    logic [LOCAL_MINERS-1:0] drop_vec;
    logic [4:0]              drop_n;
    logic [16:0]             drop_sum;
    logic [15:0]             drop_q, drop_d;

    assign drop_vec = golden_nonce_match & pend_vec & ~grant_oh;

    always_comb begin
        drop_n = '0;
        for (int i = 0; i < LOCAL_MINERS; i++) begin
            drop_n = drop_n + 5'(drop_vec[i]);
        end
        drop_sum = {1'b0, drop_q} + 17'(drop_n);
        drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge hash_clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_count = drop_q;
`else
    assign drop_count = '0;
`endif

endmodule
